// File: rtl/vm_controller_if.sv
// Vending machine controller bus: coin/purchase inputs and
// vend/change outputs grouped for master (machine) and slave (controller).
interface vm_controller_if;
  logic [3:0] money;
  logic       money_valid;
  logic [3:0] product_code;
  logic       buy;
  logic       product_ready;
  logic [3:0] ready_product_code;
  logic       product_valid;
  logic       busy;
  logic [3:0] change_denomination_code;
  logic       change_valid;
  logic       no_change;

  modport master (
    output money,
    output money_valid,
    output product_code,
    output buy,
    output product_ready,
    input  ready_product_code,
    input  product_valid,
    input  busy,
    input  change_denomination_code,
    input  change_valid,
    input  no_change
  );

  modport slave (
    input  money,
    input  money_valid,
    input  product_code,
    input  buy,
    input  product_ready,
    output ready_product_code,
    output product_valid,
    output busy,
    output change_denomination_code,
    output change_valid,
    output no_change
  );
endinterface

// File: rtl/vm_controller.sv
// Vending machine sequencer: credit accumulation, greedy change
// feasibility check, product handshake and coin-per-cycle change payout.
module vm_controller #(
  parameter int NUM_PRODUCTS = 10,
  parameter int PRICE_STEP   = 5,
  parameter int CREDIT_W     = 8,
  parameter int STOCK_W      = 4,
  parameter int COIN_INIT    = 4
) (
  input logic             clk,
  input logic             rst,
  vm_controller_if.slave  bus
);

  localparam int PW = CREDIT_W + 8;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(COIN_INIT);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    VEND,
    CHANGE
  } state_t;

  state_t state_q, state_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [3:0]          code_q, code_d;

  logic [3:0][STOCK_W-1:0] stock_q, stock_d;
  logic [3:0][STOCK_W-1:0] shadow_q, shadow_d;

  logic       pv_q, pv_d;
  logic [3:0] rpc_q, rpc_d;
  logic       busy_q, busy_d;
  logic       cv_q, cv_d;
  logic [3:0] cdc_q, cdc_d;
  logic       nc_q, nc_d;

  function automatic logic [6:0] coin_val(input logic [3:0] c);
    case (c)
      4'd0:    coin_val = 7'd1;
      4'd1:    coin_val = 7'd2;
      4'd2:    coin_val = 7'd5;
      4'd3:    coin_val = 7'd10;
      4'd4:    coin_val = 7'd20;
      4'd5:    coin_val = 7'd50;
      default: coin_val = 7'd0;
    endcase
  endfunction

  // coin acceptance
  logic                coin_ok;
  logic [CREDIT_W:0]   sum;
  logic                fits;

  assign coin_ok = (bus.money <= 4'd5);
  assign sum     = {1'b0, credit_q}
                 + (CREDIT_W+1)'(coin_val(bus.money));
  assign fits    = ~sum[CREDIT_W];

  // purchase acceptance
  logic [PW-1:0] price;
  logic          prod_ok;
  logic          afford;

  assign price   = PW'((32'(bus.product_code) + 32'd1)
                 * 32'(PRICE_STEP));
  assign prod_ok = {28'd0, bus.product_code}
                 < 32'(NUM_PRODUCTS);
  assign afford  = PW'(credit_q) >= price;

  // shared greedy picker: shadow stock while checking, real stock otherwise
  logic [CREDIT_W-1:0]     amt;
  logic [3:0][STOCK_W-1:0] stk;
  logic                    pk_ok;
  logic [1:0]              pk_idx;
  logic [CREDIT_W-1:0]     pk_val;

  assign amt = (state_q == VEND) ? credit_q - price_q : rem_q;
  assign stk = (state_q == CHECK) ? shadow_q : stock_q;

  always_comb begin
    pk_ok  = 1'b1;
    pk_idx = 2'd0;
    if (amt >= CREDIT_W'(10) && stk[3] != '0)
      pk_idx = 2'd3;
    else if (amt >= CREDIT_W'(5) && stk[2] != '0)
      pk_idx = 2'd2;
    else if (amt >= CREDIT_W'(2) && stk[1] != '0)
      pk_idx = 2'd1;
    else if (amt >= CREDIT_W'(1) && stk[0] != '0)
      pk_idx = 2'd0;
    else
      pk_ok = 1'b0;
  end

  always_comb begin
    unique case (pk_idx)
      2'd0: pk_val = CREDIT_W'(1);
      2'd1: pk_val = CREDIT_W'(2);
      2'd2: pk_val = CREDIT_W'(5);
      2'd3: pk_val = CREDIT_W'(10);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    rem_d    = rem_q;
    code_d   = code_q;
    stock_d  = stock_q;
    shadow_d = shadow_q;
    pv_d     = 1'b0;
    rpc_d    = 4'd0;
    cv_d     = 1'b0;
    cdc_d    = 4'd0;
    nc_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.money_valid) begin
          if (coin_ok && fits) begin
            credit_d = sum[CREDIT_W-1:0];
            if (bus.money <= 4'd3
                && stock_q[bus.money[1:0]] != STOCK_MAX)
              stock_d[bus.money[1:0]] =
                stock_q[bus.money[1:0]] + STOCK_W'(1);
          end
        end else if (bus.buy && prod_ok && afford) begin
          code_d   = bus.product_code;
          price_d  = price[CREDIT_W-1:0];
          rem_d    = credit_q - price[CREDIT_W-1:0];
          shadow_d = stock_q;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          state_d = VEND;
          pv_d    = 1'b1;
          rpc_d   = code_q;
        end else if (pk_ok) begin
          rem_d            = rem_q - pk_val;
          shadow_d[pk_idx] = shadow_q[pk_idx] - STOCK_W'(1);
        end else begin
          nc_d    = 1'b1;
          state_d = IDLE;
        end
      end
      VEND: begin
        if (!bus.product_ready) begin
          pv_d  = 1'b1;
          rpc_d = code_q;
        end else if (amt != '0 && pk_ok) begin
          // first change coin goes out on the cycle CHANGE is entered
          cv_d            = 1'b1;
          cdc_d           = {2'b00, pk_idx};
          stock_d[pk_idx] = stock_q[pk_idx] - STOCK_W'(1);
          rem_d           = amt - pk_val;
          state_d         = CHANGE;
        end else begin
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      CHANGE: begin
        if (rem_q != '0 && pk_ok) begin
          cv_d            = 1'b1;
          cdc_d           = {2'b00, pk_idx};
          stock_d[pk_idx] = stock_q[pk_idx] - STOCK_W'(1);
          rem_d           = rem_q - pk_val;
        end else begin
          credit_d = '0;
          state_d  = IDLE;
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      rem_q    <= '0;
      code_q   <= '0;
      stock_q  <= {4{STOCK_RST}};
      shadow_q <= {4{STOCK_RST}};
      pv_q     <= 1'b0;
      rpc_q    <= 4'd0;
      busy_q   <= 1'b0;
      cv_q     <= 1'b0;
      cdc_q    <= 4'd0;
      nc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      rem_q    <= rem_d;
      code_q   <= code_d;
      stock_q  <= stock_d;
      shadow_q <= shadow_d;
      pv_q     <= pv_d;
      rpc_q    <= rpc_d;
      busy_q   <= busy_d;
      cv_q     <= cv_d;
      cdc_q    <= cdc_d;
      nc_q     <= nc_d;
    end
  end

  assign bus.product_valid            = pv_q;
  assign bus.ready_product_code       = rpc_q;
  assign bus.busy                     = busy_q;
  assign bus.change_valid             = cv_q;
  assign bus.change_denomination_code = cdc_q;
  assign bus.no_change                = nc_q;

endmodule

// File: tb/tb_vm_controller.sv
// Directed bench for vm_controller: coin/credit vector table plus
// hand sequences for vend, change, refusal and async reset.
module tb_vm_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vm_controller_if bus ();
  vm_controller_if bus0 ();

  vm_controller #(.COIN_INIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vm_controller #(.COIN_INIT(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       mv;
    logic [3:0] money;
    logic       buy;
    logic [3:0] code;
    int         exp_credit;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.money = 4'd0;  bus.money_valid = 1'b0;
    bus.product_code = 4'd0; bus.buy = 1'b0;
    bus.product_ready = 1'b0;
    bus0.money = 4'd0; bus0.money_valid = 1'b0;
    bus0.product_code = 4'd0; bus0.buy = 1'b0;
    bus0.product_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic coin(input logic [3:0] m);
    bus.money = m;
    bus.money_valid = 1'b1;
    step();
    bus.money_valid = 1'b0;
  endtask

  task automatic buy(input logic [3:0] c);
    bus.product_code = c;
    bus.buy = 1'b1;
    step();
    bus.buy = 1'b0;
  endtask

  task automatic wait_pv(input int n);
    int k;
    k = 0;
    while (!bus.product_valid && k < n) begin
      step();
      k++;
    end
    chk("pv_wait", int'(bus.product_valid), 1);
  endtask

  function automatic int outs(input logic dummy);
    outs = int'({bus.product_valid, bus.busy, bus.change_valid,
                 bus.no_change, bus.ready_product_code,
                 bus.change_denomination_code});
  endfunction

  task automatic post_reset_chk(input string nm);
    chk({nm, "_credit"}, int'(dut.credit_q), 0);
    for (int i = 0; i < 4; i++)
      chk({nm, "_stock"}, int'(dut.stock_q[i]), 4);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    logic [3:0] exp_codes[5];
    int k;
    exp_codes[0] = 4'd3; exp_codes[1] = 4'd3;
    exp_codes[2] = 4'd3; exp_codes[3] = 4'd3;
    exp_codes[4] = 4'd2;

    vt[0]  = '{1'b1, 4'd0, 1'b0, 4'd0, 1};
    vt[1]  = '{1'b1, 4'd1, 1'b0, 4'd0, 3};
    vt[2]  = '{1'b1, 4'd2, 1'b0, 4'd0, 8};
    vt[3]  = '{1'b1, 4'd7, 1'b0, 4'd0, 8};
    vt[4]  = '{1'b0, 4'd0, 1'b1, 4'd5, 8};
    vt[5]  = '{1'b1, 4'd4, 1'b0, 4'd0, 28};
    vt[6]  = '{1'b1, 4'd5, 1'b0, 4'd0, 78};
    vt[7]  = '{1'b1, 4'd5, 1'b0, 4'd0, 128};
    vt[8]  = '{1'b1, 4'd5, 1'b0, 4'd0, 178};
    vt[9]  = '{1'b1, 4'd5, 1'b0, 4'd0, 228};
    vt[10] = '{1'b1, 4'd5, 1'b0, 4'd0, 228};
    vt[11] = '{1'b1, 4'd4, 1'b0, 4'd0, 248};
    vt[12] = '{1'b1, 4'd3, 1'b0, 4'd0, 248};
    vt[13] = '{1'b1, 4'd2, 1'b0, 4'd0, 253};
    vt[14] = '{1'b1, 4'd1, 1'b1, 4'd0, 255};
    vt[15] = '{1'b1, 4'd0, 1'b0, 4'd0, 255};
    vt[16] = '{1'b0, 4'd3, 1'b0, 4'd0, 255};

    do_reset();
    chk("rst_outs", outs(1'b0), 0);
    post_reset_chk("rst");

    // no change possible with empty stock
    bus0.money = 4'd4; bus0.money_valid = 1'b1;
    step();
    bus0.money_valid = 1'b0;
    bus0.product_code = 4'd0; bus0.buy = 1'b1;
    step();
    bus0.buy = 1'b0;
    chk("nc_busy_check", int'(bus0.busy), 1);
    chk("nc_early", int'(bus0.no_change), 0);
    step();
    chk("nc_pulse", int'(bus0.no_change), 1);
    chk("nc_busy_low", int'(bus0.busy), 0);
    chk("nc_pv", int'(bus0.product_valid), 0);
    step();
    chk("nc_pulse_end", int'(bus0.no_change), 0);
    chk("nc_credit", int'(dut0.credit_q), 20);
    bus0.money = 4'd2; bus0.money_valid = 1'b1;
    step();
    bus0.money_valid = 1'b0;
    bus0.product_code = 4'd3; bus0.buy = 1'b1;
    step();
    bus0.buy = 1'b0;
    k = 0;
    while (!bus0.product_valid && k < 10) begin
      chk("nc2_no_pulse", int'(bus0.no_change), 0);
      step();
      k++;
    end
    chk("nc2_pv", int'(bus0.product_valid), 1);
    chk("nc2_rpc", int'(bus0.ready_product_code), 3);
    bus0.product_ready = 1'b1;
    step();
    bus0.product_ready = 1'b0;
    chk("nc2_cv", int'(bus0.change_valid), 1);
    chk("nc2_cdc", int'(bus0.change_denomination_code), 2);
    step();
    chk("nc2_cv_end", int'(bus0.change_valid), 0);
    chk("nc2_busy", int'(bus0.busy), 0);

    // coin / buy vector table
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.money_valid  = vt[i].mv;
      bus.money        = vt[i].money;
      bus.buy          = vt[i].buy;
      bus.product_code = vt[i].code;
      step();
      chk($sformatf("vec%0d_credit", i), int'(dut.credit_q),
          vt[i].exp_credit);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
    end
    idle_inputs();
    step();
    chk("vec_stock0", int'(dut.stock_q[0]), 5);
    chk("vec_stock1", int'(dut.stock_q[1]), 6);
    chk("vec_stock2", int'(dut.stock_q[2]), 6);
    chk("vec_stock3", int'(dut.stock_q[3]), 4);

    // buy rejected for lack of credit
    do_reset();
    coin(4'd2);
    buy(4'd1);
    chk("rej_busy", int'(bus.busy), 0);
    step();
    chk("rej_busy2", int'(bus.busy), 0);
    chk("rej_nc", int'(bus.no_change), 0);
    chk("rej_credit", int'(dut.credit_q), 5);

    // exact payment
    do_reset();
    coin(4'd2);
    buy(4'd0);
    chk("exact_check_busy", int'(bus.busy), 1);
    chk("exact_check_pv", int'(bus.product_valid), 0);
    step();
    chk("exact_pv", int'(bus.product_valid), 1);
    chk("exact_rpc", int'(bus.ready_product_code), 0);
    bus.product_ready = 1'b1;
    step();
    bus.product_ready = 1'b0;
    chk("exact_pv_low", int'(bus.product_valid), 0);
    chk("exact_busy_low", int'(bus.busy), 0);
    chk("exact_cv", int'(bus.change_valid), 0);
    chk("exact_credit", int'(dut.credit_q), 0);

    // single change coin, product held while dispenser stalls
    do_reset();
    coin(4'd3);
    coin(4'd3);
    buy(4'd2);
    wait_pv(10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pv", int'(bus.product_valid), 1);
      chk("hold_rpc", int'(bus.ready_product_code), 2);
    end
    bus.product_ready = 1'b1;
    step();
    bus.product_ready = 1'b0;
    chk("chg1_cv", int'(bus.change_valid), 1);
    chk("chg1_cdc", int'(bus.change_denomination_code), 2);
    chk("chg1_pv", int'(bus.product_valid), 0);
    step();
    chk("chg1_cv_end", int'(bus.change_valid), 0);
    chk("chg1_busy", int'(bus.busy), 0);
    chk("chg1_stock5", int'(dut.stock_q[2]), 3);
    chk("chg1_credit", int'(dut.credit_q), 0);

    // multi-coin change: 45 = 10+10+10+10+5
    do_reset();
    coin(4'd5);
    buy(4'd0);
    wait_pv(20);
    bus.product_ready = 1'b1;
    step();
    bus.product_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("multi%0d_cv", i), int'(bus.change_valid), 1);
      chk($sformatf("multi%0d_cdc", i),
          int'(bus.change_denomination_code), int'(exp_codes[i]));
      step();
    end
    chk("multi_cv_end", int'(bus.change_valid), 0);
    chk("multi_busy", int'(bus.busy), 0);
    chk("multi_stock10", int'(dut.stock_q[3]), 0);

    // async reset during VEND
    do_reset();
    coin(4'd2);
    buy(4'd0);
    wait_pv(10);
    #2 rst = 1'b0;
    #1 chk("rst_vend_outs", outs(1'b0), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    post_reset_chk("rst_vend");

    // async reset during CHANGE
    coin(4'd5);
    buy(4'd0);
    wait_pv(20);
    bus.product_ready = 1'b1;
    step();
    bus.product_ready = 1'b0;
    chk("rst_chg_cv", int'(bus.change_valid), 1);
    #2 rst = 1'b0;
    #1 chk("rst_chg_outs", outs(1'b0), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    post_reset_chk("rst_chg");
    step();
    chk("rst_chg_idle_cv", int'(bus.change_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vm_controller.md
Name: vm_controller

Overview:
- Central sequencer of the vending machine; sits between the input-side signal group (money, money_valid, product_code, buy, product_ready) and the output-side group (ready_product_code, product_valid, busy, change_denomination_code, change_valid, no_change).
- Accumulates credit from inserted coins and tracks change-coin stock.
- Checks change feasibility before vending, then handshakes product delivery and pays change one coin per cycle.

Parameters:
- NUM_PRODUCTS, 10, number of valid product codes (0..NUM_PRODUCTS-1, max 16).
- PRICE_STEP, 5, price(code) = (code+1)*PRICE_STEP.
- CREDIT_W, 8, credit register width; CREDIT_MAX = 2^CREDIT_W-1.
- STOCK_W, 4, width of each change-coin stock counter; STOCK_MAX = 2^STOCK_W-1.
- COIN_INIT, 4, reset value of every stock counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- money  in  4  denomination code of inserted coin.
- money_valid  in  1  coin present this cycle.
- product_code  in  4  requested product.
- buy  in  1  purchase request, sampled in IDLE.
- product_ready  in  1  dispenser has delivered the product.
- ready_product_code  out  4  product being vended.
- product_valid  out  1  vend request to dispenser.
- busy  out  1  controller not in IDLE.
- change_denomination_code  out  4  code of change coin paid this cycle.
- change_valid  out  1  one change coin paid this cycle.
- no_change  out  1  one-cycle pulse: purchase refused, change cannot be made.

Behaviour:
- Denomination codes and values: 0=1, 1=2, 2=5, 3=10, 4=20, 5=50. Codes 6-15 are invalid and ignored. Change is paid only in codes 0-3.
- Reset (rst low, asynchronous):
  - All outputs 0, state IDLE, credit 0.
  - All four stock counters = COIN_INIT.
- All outputs are registered.
- IDLE, coin insertion:
  - money_valid with a valid code is accepted only if credit+value <= CREDIT_MAX; otherwise the coin is rejected and credit is unchanged.
  - An accepted coin of code 0-3 increments that stock counter, saturating at STOCK_MAX.
- IDLE, purchase:
  - buy is accepted only if all hold: money_valid=0 the same cycle (coin wins, buy ignored), product_code < NUM_PRODUCTS, and credit >= price.
  - A rejected buy is a no-op: no pulse, state unchanged.
  - On acceptance: latch code and price, remaining <= credit-price, shadow stocks <= stocks, go to CHECK.
- CHECK (one greedy step per cycle):
  - If remaining == 0: go to VEND.
  - Else pick the largest d in {10,5,2,1} with d <= remaining and shadow[d] > 0; subtract d and decrement shadow[d].
  - If no such d exists: pulse no_change for 1 cycle, return to IDLE with credit unchanged.
  - Worst case ~ CREDIT_MAX/10 + 4 cycles.
- VEND:
  - product_valid=1 and ready_product_code=latched code, held stable until product_ready is sampled 1.
  - Then product_valid <= 0 and remaining <= credit-price.
  - Go to CHANGE if remaining > 0, else IDLE with credit <= 0.
- CHANGE (greedy, same rule as CHECK, on real stocks):
  - Each cycle: change_valid=1, change_denomination_code = code of the chosen d; decrement stock[d] and remaining.
  - When remaining reaches 0: the next cycle is IDLE, change_valid=0, credit=0.
  - Success in CHECK guarantees CHANGE always completes.
- busy=1 in CHECK, VEND and CHANGE; it deasserts in the same cycle the state returns to IDLE.
- money_valid and buy outside IDLE are ignored: credit and stock are unchanged.
- product_ready outside VEND is ignored.
- Reset mid-operation clears everything immediately; an in-flight vend or change is abandoned.

Test Plan:
- Exact payment (COIN_INIT=4): money=2 (5), buy code 0 (price 5) -> CHECK 1 cycle, then product_valid=1, ready_product_code=0; product_ready=1 -> IDLE, no change_valid, credit 0.
- Change path: money=3, money=3 (credit 20), buy code 2 (price 15) -> product_valid held across 3 cycles of product_ready=0; after product_ready: exactly one change_valid with code 2 (5), stock5 3, busy low the next cycle.
- Multi-coin change: money=5 (50), buy code 0 -> change 45 paid as codes 3,3,3,3,2 on 5 consecutive cycles.
- No change (COIN_INIT=0): money=4 (20), buy code 0 -> no_change 1-cycle pulse, product_valid never set, credit stays 20. Then money=2, buy code 3 (price 20) -> vends, change code 2 once.
- Rejections: credit 5, buy code 1 -> busy stays 0, no pulses. Five money=5 coins (credit 250), then money=3 -> credit stays 250. money=7 -> ignored. money_valid and buy in the same cycle -> coin credited, buy ignored.
- Reset mid-VEND and mid-CHANGE: rst low -> all outputs 0 in the same cycle without a clock edge. After release: credit 0, stocks COIN_INIT, IDLE.
